// File: rtl/hps_disk_pkg.sv
// hps_disk_pkg: shared types and constants for the HPS disk slave.
//   - FSM state enum
//   - Avalon region decode (address bits [11:10])
//   - control-window word offsets (address bits [3:2])
//   - status word bit positions and a helper that packs the status word
package hps_disk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [1:0] REG_BUF = 2'd0;
    localparam logic [1:0] REG_CTL = 2'd1;

    localparam logic [1:0] CTL_STATUS = 2'd0;
    localparam logic [1:0] CTL_LBA    = 2'd1;
    localparam logic [1:0] CTL_DEPTH  = 2'd2;

    localparam int ST_DEVICE_BIT  = 0;
    localparam int ST_OPWR_BIT    = 1;
    localparam int ST_BUSY_BIT    = 2;
    localparam int ST_TIMEOUT_BIT = 3;
    localparam int ST_SEQ_LSB     = 8;

    function automatic logic [31:0] status_word(input logic [7:0] seq,
                                                input logic timeout,
                                                input logic busy,
                                                input logic op_write,
                                                input logic device);
        logic [31:0] w;
        w                   = '0;
        w[ST_SEQ_LSB +: 8]  = seq;
        w[ST_TIMEOUT_BIT]   = timeout;
        w[ST_BUSY_BIT]      = busy;
        w[ST_OPWR_BIT]      = op_write;
        w[ST_DEVICE_BIT]    = device;
        return w;
    endfunction

endpackage

// File: rtl/hps_disk_buf.sv
// hps_disk_buf: single-port BUF_WORDS x 32 sector buffer, registered read.
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  read data, valid the cycle after addr is presented
// No reset: contents and output register are left to the RAM macro.
module hps_disk_buf #(
    parameter int BUF_WORDS = 128,
    parameter int AW        = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [BUF_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hps_disk_slave.sv
// hps_disk_slave: Avalon-MM slave for the HPS DMA bridge plus the disk
// request handshake toward HPS firmware.
//   avs_*          Avalon slave: region 0 = sector buffer, region 1 = control
//                  window (status / LBA / depth), regions 2-3 read as zero
//   cmd_*          core-side sector command post / completion
//   buf_*          core-side buffer port, priority over Avalon
//   disk_op_*      level request toward HPS, disk_result_* level results
// Optional macro HPS_TIMEOUT_EN: a request left unanswered for
// TIMEOUT_CYCLES completes with an error and sets the sticky timeout bit.
module hps_disk_slave
    import hps_disk_pkg::*;
#(
    parameter int BUF_WORDS      = 128,
    parameter int AW             = 7,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    output logic          avs_waitrequest,
    output logic [31:0]   avs_readdata,
    output logic          avs_readdatavalid,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic          cmd_device,
    input  logic [31:0]   cmd_lba,
    output logic          cmd_done,
    output logic          cmd_error,
    input  logic [AW-1:0] buf_addr,
    input  logic          buf_rd,
    input  logic          buf_wr,
    input  logic [31:0]   buf_wdata,
    output logic [31:0]   buf_rdata,
    output logic          disk_op_read,
    output logic          disk_op_write,
    output logic          disk_op_device,
    input  logic          disk_result_ok,
    input  logic          disk_result_error
);

    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        op_write_q, err_q, ok_prev_q, err_prev_q;
    logic [31:0] lba_q;
    logic [7:0]  seq_q;
    logic        timeout_q, to_hit;

    // Results are edge-triggered so a level left high from the previous
    // command cannot complete the next one.
    logic ok_rise, err_rise, result_hit;
    assign ok_rise    = disk_result_ok & ~ok_prev_q;
    assign err_rise   = disk_result_error & ~err_prev_q;
    assign result_hit = ok_rise | err_rise;

    assign cmd_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_REQ;
            ST_REQ:  if (result_hit || to_hit) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_write_q     <= 1'b0;
            disk_op_device <= 1'b0;
            lba_q          <= '0;
            seq_q          <= '0;
            err_q          <= 1'b0;
            ok_prev_q      <= 1'b0;
            err_prev_q     <= 1'b0;
            disk_op_read   <= 1'b0;
            disk_op_write  <= 1'b0;
            cmd_done       <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ok_prev_q  <= disk_result_ok;
            err_prev_q <= disk_result_error;
            cmd_done   <= 1'b0;
            cmd_error  <= 1'b0;
            case (state_q)
                ST_IDLE: if (cmd_valid) begin
                    op_write_q     <= cmd_write;
                    disk_op_device <= cmd_device;
                    lba_q          <= cmd_lba;
                    seq_q          <= seq_q + 8'd1;
                    disk_op_read   <= ~cmd_write;
                    disk_op_write  <= cmd_write;
                end
                ST_REQ: if (result_hit) begin
                    // error level wins whenever it is high with the result
                    err_q         <= disk_result_error;
                    disk_op_read  <= 1'b0;
                    disk_op_write <= 1'b0;
                end else if (to_hit) begin
                    err_q         <= 1'b1;
                    disk_op_read  <= 1'b0;
                    disk_op_write <= 1'b0;
                end
                ST_FIN: begin
                    cmd_done  <= 1'b1;
                    cmd_error <= err_q;
                end
                default: ;
            endcase
        end
    end

`ifdef HPS_TIMEOUT_EN
    logic [25:0] to_cnt_q;
    assign to_hit = (state_q == ST_REQ) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            to_cnt_q <= '0;
            if (cmd_valid) timeout_q <= 1'b0;
        end else if (state_q == ST_REQ) begin
            to_cnt_q <= to_cnt_q + 26'd1;
            if (to_hit && !result_hit) timeout_q <= 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_q = 1'b0;
`endif

    // ---------------- Avalon / buffer arbitration ----------------
    logic [1:0]    region, ctl_off;
    logic [AW-1:0] hps_idx;
    logic          hps_req, core_req, hps_acc, hps_rd_acc;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_q, ctl_rdata;
    logic          rd_vld_q, rd_buf_q, core_rd_q;
    logic [31:0]   reg_rdata_q;

    assign region   = avs_address[11:10];
    assign ctl_off  = avs_address[3:2];
    assign hps_idx  = avs_address[AW+1:2];
    assign hps_req  = avs_read | avs_write;
    assign core_req = buf_rd | buf_wr;

    // Only buffer accesses contend for the RAM; the register window never stalls.
    assign avs_waitrequest = hps_req && (region == REG_BUF) && core_req;
    assign hps_acc         = hps_req & ~avs_waitrequest;
    assign hps_rd_acc      = hps_acc & ~avs_write;

    assign ram_addr  = core_req ? buf_addr  : hps_idx;
    assign ram_wdata = core_req ? buf_wdata : avs_writedata;
    assign ram_we    = core_req ? buf_wr
                                : (hps_acc && avs_write && (region == REG_BUF));

    hps_disk_buf #(.BUF_WORDS(BUF_WORDS), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_comb begin
        ctl_rdata = '0;
        case (ctl_off)
            CTL_STATUS: ctl_rdata = status_word(seq_q, timeout_q, state_q != ST_IDLE,
                                                op_write_q, disk_op_device);
            CTL_LBA:    ctl_rdata = lba_q;
            CTL_DEPTH:  ctl_rdata = 32'(BUF_WORDS);
            default:    ctl_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            core_rd_q   <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            rd_vld_q    <= hps_rd_acc;
            rd_buf_q    <= (region == REG_BUF);
            core_rd_q   <= buf_rd & ~buf_wr;
            reg_rdata_q <= (region == REG_CTL) ? ctl_rdata : '0;
        end
    end

    // RAM output has no reset, so both read ports are gated by their strobes.
    assign avs_readdatavalid = rd_vld_q;
    assign avs_readdata      = !rd_vld_q ? '0 : (rd_buf_q ? ram_q : reg_rdata_q);
    assign buf_rdata         = core_rd_q ? ram_q : '0;

    logic unused_ok;
    assign unused_ok = ^{avs_address, TO_LAST};

endmodule

// File: doc/hps_disk_slave.md
Name: hps_disk_slave

Overview:
System-side responder to the HPS DMA bridge's Avalon-MM master (mem_* port) and source of the disk_op_* / disk_result_* handshake. It holds a one-sector word buffer shared between the HPS side and the core-side disk controllers (IDE/floppy), and exposes a small command register window so HPS firmware can read the pending LBA and device. A core controller posts one sector command at a time, and this block raises the disk request until HPS reports a result.

Parameters:
BUF_WORDS, 128, sector buffer depth in 32-bit words (512 bytes); power of two.
AW, 7, log2(BUF_WORDS).
TIMEOUT_CYCLES, 50000000, request timeout in clk cycles (HPS_TIMEOUT_EN only).

Ports:
clk  in  1  system clock (clk_sys domain)
rst_n  in  1  asynchronous active-low reset
avs_address  in  32  byte address from bridge; [11:10] region, [AW+1:2] word index
avs_read  in  1  Avalon read
avs_write  in  1  Avalon write
avs_writedata  in  32  write data
avs_waitrequest  out  1  stall current transfer
avs_readdata  out  32  read data
avs_readdatavalid  out  1  read data strobe
cmd_valid  in  1  core posts command
cmd_ready  out  1  block idle, can accept
cmd_write  in  1  1 = sector write to disk, 0 = read
cmd_device  in  1  0 = floppy, 1 = HDD
cmd_lba  in  32  sector address
cmd_done  out  1  one-cycle completion pulse
cmd_error  out  1  valid with cmd_done
buf_addr  in  AW  core buffer word address
buf_rd  in  1  core buffer read
buf_wr  in  1  core buffer write
buf_wdata  in  32  core write data
buf_rdata  out  32  core read data, 1-cycle latency
disk_op_read  out  1  level request, HPS reads disk into buffer
disk_op_write  out  1  level request, HPS writes buffer to disk
disk_op_device  out  1  latched cmd_device
disk_result_ok  in  1  HPS result ok (level)
disk_result_error  in  1  HPS result error (level)

Behaviour:
- Reset (async, rst_n=0): state IDLE. disk_op_* = 0. avs_waitrequest = 0. avs_readdatavalid = 0. avs_readdata = 0. cmd_done = 0. cmd_error = 0. buf_rdata = 0. LBA = 0. Sequence counter = 0. cmd_ready = 1, because it is combinational (state==IDLE). Reset during REQ drops the request immediately. Buffer contents are not cleared.
- FSM states are IDLE, REQ, FIN.
  - IDLE: on cmd_valid, latch write/device/lba, increment 8-bit seq (wraps 255->0), and go to REQ.
  - REQ: disk_op_read = ~op_write and disk_op_write = op_write, both registered. Go to FIN on the first cycle in which ok or error is sampled high (a rising edge relative to the previous cycle). If both ok and error are high, error wins.
  - FIN: cmd_done = 1 for one cycle, cmd_error = error flag, then IDLE. cmd_valid in REQ/FIN is ignored.
- Result lines that are already high when REQ is entered are not accepted until they fall and rise again.
- Buffer is single-port RAM. The core port has priority.
  - An HPS region-0 access in a cycle with buf_rd|buf_wr gets avs_waitrequest=1 and is accepted on the next free cycle.
  - Word index is taken modulo BUF_WORDS.
- Avalon reads:
  - Fixed latency: readdatavalid exactly one cycle after the accepted (waitrequest=0) read.
  - Back-to-back reads are accepted every free cycle. Read and write asserted together are treated as a write.
- Region 1 register window, read-only:
  - word0 = {16'h0, seq[7:0], 4'h0, timeout, busy, op_write, device}
  - word1 = LBA
  - word2 = BUF_WORDS
  - Writes are accepted and discarded. Never stalled.
- Regions 2-3: reads return 0, writes are discarded.
- Core and HPS writes to the same word in different cycles: the last write wins.

Optional Feature:
HPS_TIMEOUT_EN.
- Defined: a 26-bit counter runs in REQ. Reaching TIMEOUT_CYCLES forces FIN with cmd_error=1 and sets the sticky timeout bit (word0[3]). That bit clears when the next command is accepted.
- Undefined: no counter. REQ waits indefinitely. word0[3] reads 0.

Decomposition:
- hps_disk_pkg holds:
  - state enum
  - region constants REG_BUF=2'd0, REG_CTL=2'd1
  - register word offsets
  - status bit positions
- Sub-module hps_disk_buf: single-port BUF_WORDS x 32 RAM with registered read, inferred as M10K. The arbiter stays in the top module.

Test Plan:
- Read command: cmd_valid with write=0, device=1, lba=0x1234. Expect next cycle disk_op_read=1, disk_op_device=1, and reg word1=0x1234. Pulse ok. Expect cmd_done=1 with cmd_error=0 two cycles later, and disk_op_read=0.
- HPS write then core read: HPS writes 0xDEADBEEF to avs_address 0x1FC (word 127). Expect core buf_addr=127 to return 0xDEADBEEF one cycle after buf_rd. An HPS write to address 0x200 must alias to word 0.
- Collision: core buf_rd and HPS read of word 5 in the same cycle. Expect avs_waitrequest=1 for one cycle, then readdatavalid one cycle after acceptance with the correct data.
- ok and error high together in REQ -> cmd_error=1. Error already high on REQ entry -> no completion until it falls and rises.
- Assert rst_n=0 mid-REQ -> disk_op_write=0 immediately and cmd_ready=1. Seq counter wraps 255->0 after 256 commands.
- HPS_TIMEOUT_EN with TIMEOUT_CYCLES=100 and no result -> cmd_done with cmd_error=1 at cycle 100+1, and word0[3]=1.
